// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S constants for the transmitter and receiver
package i2s_pkg;

  localparam int   SLOT_W_DEFAULT = 32;
  localparam int   FRAME_BITS     = 2 * SLOT_W_DEFAULT;
  localparam logic WS_LEFT        = 1'b0;
  localparam logic WS_RIGHT       = 1'b1;
  localparam int   LATCH_SLOT     = 1;

  function automatic logic ws_for_slot(input int slot, input int slot_w);
    return (slot >= slot_w) ? WS_RIGHT : WS_LEFT;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - BCLK/WS generator with slot counter and falling-edge strobe
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int SLOT_W  = SLOT_W_DEFAULT,
  parameter int CLK_DIV = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  output logic                          bclk,
  output logic                          ws,
  output logic [$clog2(2*SLOT_W)-1:0]   k,
  output logic                          fall_evt
);

  localparam int KW    = $clog2(2 * SLOT_W);
  localparam int K_MAX = 2 * SLOT_W - 1;

  logic [7:0]    div_cnt;
  logic          div_wrap;
  logic [KW-1:0] k_nxt;

  assign div_wrap = en && (div_cnt == 8'(CLK_DIV - 1));
  assign fall_evt = div_wrap && bclk;
  assign k_nxt    = (k == KW'(K_MAX)) ? '0 : k + KW'(1);

  // k starts at the last slot so the first falling edge opens slot 0
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      ws      <= WS_LEFT;
      k       <= KW'(K_MAX);
    end else if (en) begin
      if (div_wrap) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      if (fall_evt) begin
        k  <= k_nxt;
        ws <= ws_for_slot(int'(k_nxt), SLOT_W);
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S master transmitter with one-frame holding buffer
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int SLOT_W  = SLOT_W_DEFAULT,
  parameter int CLK_DIV = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [SLOT_W-1:0] l_data,
  input  logic [SLOT_W-1:0] r_data,
  input  logic              valid,
  output logic              ready,
  output logic              BCLK,
  output logic              WS,
  output logic              DOUT,
  output logic              frame_start,
  output logic              underrun
);

  localparam int FB = 2 * SLOT_W;
  localparam int KW = $clog2(FB);

  logic [KW-1:0] k;
  logic          fall_evt;
  logic          latch;
  logic          xfer;
  logic          wt;
  logic          buf_full;
  logic          buf_full_nxt;
  logic [FB-1:0] buf_q;
  logic [FB-1:0] shifter;
  logic [FB-1:0] frame_src;

  i2s_clkgen #(
    .SLOT_W  (SLOT_W),
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bclk     (BCLK),
    .ws       (WS),
    .k        (k),
    .fall_evt (fall_evt)
  );

  assign xfer  = valid && ready;
  assign latch = fall_evt && (k == KW'(LATCH_SLOT - 1));
  // An empty buffer at latch time lets a same-cycle frame bypass straight into the shifter
  assign wt    = latch && !buf_full && xfer;
  assign frame_src = buf_full ? buf_q : (wt ? {l_data, r_data} : '0);

  always_comb begin
    buf_full_nxt = buf_full;
    if (latch && buf_full)
      buf_full_nxt = 1'b0;
    else if (xfer && !wt)
      buf_full_nxt = 1'b1;
  end

  // The shifter runs MSB-first from slot 1; its last bit lands in slot 0 of the next frame
  always_ff @(posedge clk) begin
    if (rst) begin
      ready       <= 1'b0;
      buf_full    <= 1'b0;
      buf_q       <= '0;
      shifter     <= '0;
      DOUT        <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      ready       <= !buf_full_nxt;
      buf_full    <= buf_full_nxt;
      frame_start <= latch && (buf_full || wt);
      underrun    <= latch && !buf_full && !wt;
      if (xfer && !wt)
        buf_q <= {l_data, r_data};
      if (latch) begin
        DOUT    <= frame_src[FB-1];
        shifter <= {frame_src[FB-2:0], 1'b0};
      end else if (fall_evt) begin
        DOUT    <= shifter[FB-1];
        shifter <= {shifter[FB-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - directed self-checking bench for i2s_tx
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] l_data = '0;
  logic [31:0] r_data = '0;
  logic        ready, BCLK, WS, DOUT, frame_start, underrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  i2s_tx #(.SLOT_W(32), .CLK_DIV(3)) dut (
    .clk(clk), .rst(rst), .en(en), .l_data(l_data), .r_data(r_data), .valid(valid),
    .ready(ready), .BCLK(BCLK), .WS(WS), .DOUT(DOUT), .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; valid = 1'b0; l_data = '0; r_data = '0;
    step(); step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; valid = 1'b0;
    step(); step();
    n_cmp++; if ({BCLK, WS, DOUT, ready, frame_start, underrun} !== 6'b0) begin n_bad++; $display("FAIL reset_outputs: got %b want 000000", {BCLK, WS, DOUT, ready, frame_start, underrun}); end
    rst = 1'b0; cyc = 0;
    step();
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL ready_rise: got %b want 1", ready); end
    wait_until(2);
    n_cmp++; if (BCLK !== 1'b0) begin n_bad++; $display("FAIL bclk_c2: got %b want 0", BCLK); end
    wait_until(3);
    n_cmp++; if (BCLK !== 1'b1) begin n_bad++; $display("FAIL bclk_first_rise: got %b want 1", BCLK); end
    wait_until(5);
    n_cmp++; if (BCLK !== 1'b1) begin n_bad++; $display("FAIL bclk_c5: got %b want 1", BCLK); end
    wait_until(6);
    n_cmp++; if (BCLK !== 1'b0) begin n_bad++; $display("FAIL bclk_first_fall: got %b want 0", BCLK); end
    wait_until(197);
    n_cmp++; if (WS !== 1'b0) begin n_bad++; $display("FAIL ws_c197: got %b want 0", WS); end
    wait_until(198);
    n_cmp++; if (WS !== 1'b1) begin n_bad++; $display("FAIL ws_rise_c198: got %b want 1", WS); end
    wait_until(389);
    n_cmp++; if (WS !== 1'b1) begin n_bad++; $display("FAIL ws_c389: got %b want 1", WS); end
    wait_until(390);
    n_cmp++; if (WS !== 1'b0) begin n_bad++; $display("FAIL ws_fall_c390: got %b want 0", WS); end
  endtask

  task automatic test_frame();
    logic [63:0] cap;
    do_reset();
    valid = 1'b1; l_data = 32'hA5A5_0001; r_data = 32'h8000_00FF;
    wait_until(2);
    valid = 1'b0;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL frame_ready_drop: got %b want 0", ready); end
    wait_until(6);
    n_cmp++; if (DOUT !== 1'b0) begin n_bad++; $display("FAIL first_k0_dout: got %b want 0", DOUT); end
    wait_until(11);
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL fs_before_latch: got %b want 0", frame_start); end
    wait_until(12);
    n_cmp++; if ({frame_start, underrun, ready} !== 3'b101) begin n_bad++; $display("FAIL latch_pulses: got %b want 101", {frame_start, underrun, ready}); end
    cap = {63'b0, DOUT};
    wait_until(13);
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL fs_one_cycle: got %b want 0", frame_start); end
    for (int j = 2; j <= 64; j++) begin
      wait_until(12 + 6 * (j - 1));
      cap = {cap[62:0], DOUT};
      if (j == 31) begin
        n_cmp++; if (WS !== 1'b0) begin n_bad++; $display("FAIL ws_left_k31: got %b want 0", WS); end
      end
      if (j == 33) begin
        n_cmp++; if (WS !== 1'b1) begin n_bad++; $display("FAIL ws_right_k33: got %b want 1", WS); end
      end
    end
    n_cmp++; if (cap[63:32] !== 32'hA5A5_0001) begin n_bad++; $display("FAIL frame_left: got %h want a5a50001", cap[63:32]); end
    n_cmp++; if (cap[31:0] !== 32'h8000_00FF) begin n_bad++; $display("FAIL frame_right: got %h want 800000ff", cap[31:0]); end
  endtask

  task automatic test_underrun();
    int nun, nfs;
    logic dor, u12, u396;
    do_reset();
    nun = 0; nfs = 0; dor = 1'b0; u12 = 1'b0; u396 = 1'b0;
    while (cyc < 400) begin
      step();
      if (underrun) nun++;
      if (frame_start) nfs++;
      dor = dor | DOUT;
      if (cyc == 12) u12 = underrun;
      if (cyc == 396) u396 = underrun;
    end
    n_cmp++; if (u12 !== 1'b1) begin n_bad++; $display("FAIL underrun_k1_first: got %b want 1", u12); end
    n_cmp++; if (u396 !== 1'b1) begin n_bad++; $display("FAIL underrun_k1_second: got %b want 1", u396); end
    n_cmp++; if (nun !== 2) begin n_bad++; $display("FAIL underrun_count: got %0d want 2", nun); end
    n_cmp++; if (nfs !== 0) begin n_bad++; $display("FAIL underrun_fs_count: got %0d want 0", nfs); end
    n_cmp++; if (dor !== 1'b0) begin n_bad++; $display("FAIL underrun_dout: got %b want 0", dor); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] cap3 [3];
    logic [63:0] exp_w;
    int nx, nfs, nun, idx;
    logic xf, rdy200;
    do_reset();
    valid = 1'b1; nx = 0; nfs = 0; nun = 0; rdy200 = 1'b1;
    for (int f = 0; f < 3; f++) cap3[f] = '0;
    while (cyc < 1160) begin
      l_data = 32'h1000_0000 + 32'(nx);
      r_data = 32'h2000_0000 + 32'(nx);
      xf = ready;
      step();
      if (xf) nx++;
      if (frame_start) nfs++;
      if (underrun) nun++;
      if (cyc == 200) rdy200 = ready;
      if (cyc >= 12 && (cyc - 12) % 6 == 0 && (cyc - 12) / 6 < 192) begin
        idx = (cyc - 12) / 6;
        cap3[idx / 64] = {cap3[idx / 64][62:0], DOUT};
      end
    end
    valid = 1'b0;
    n_cmp++; if (nx !== 4) begin n_bad++; $display("FAIL b2b_transfers: got %0d want 4", nx); end
    n_cmp++; if (nfs !== 3) begin n_bad++; $display("FAIL b2b_frame_starts: got %0d want 3", nfs); end
    n_cmp++; if (nun !== 0) begin n_bad++; $display("FAIL b2b_underruns: got %0d want 0", nun); end
    n_cmp++; if (rdy200 !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_between: got %b want 0", rdy200); end
    for (int f = 0; f < 3; f++) begin
      exp_w = {32'h1000_0000 + 32'(f), 32'h2000_0000 + 32'(f)};
      n_cmp++; if (cap3[f] !== exp_w) begin n_bad++; $display("FAIL b2b_frame%0d: got %h want %h", f, cap3[f], exp_w); end
    end
  endtask

  task automatic test_enable_pause();
    logic [63:0] cap;
    logic frz_bad, rdy_after;
    do_reset();
    valid = 1'b1; l_data = 32'hCAFE_B00D; r_data = 32'h1357_9BDF;
    wait_until(2);
    valid = 1'b0;
    cap = '0;
    for (int j = 1; j <= 17; j++) begin
      wait_until(12 + 6 * (j - 1));
      cap = {cap[62:0], DOUT};
    end
    en = 1'b0; frz_bad = 1'b0; rdy_after = 1'b1;
    for (int p = 0; p < 50; p++) begin
      valid = (p == 10);
      l_data = 32'h0F0F_0F0F; r_data = 32'hF0F0_F0F0;
      step();
      if (BCLK !== 1'b0 || WS !== 1'b0 || DOUT !== 1'b1 || frame_start !== 1'b0 || underrun !== 1'b0) frz_bad = 1'b1;
      if (p == 10) rdy_after = ready;
    end
    valid = 1'b0; en = 1'b1;
    n_cmp++; if (frz_bad !== 1'b0) begin n_bad++; $display("FAIL pause_frozen: got %b want 0", frz_bad); end
    n_cmp++; if (rdy_after !== 1'b0) begin n_bad++; $display("FAIL pause_handshake: got %b want 0", rdy_after); end
    wait_until(163);
    n_cmp++; if (DOUT !== 1'b1) begin n_bad++; $display("FAIL resume_bit15: got %b want 1", DOUT); end
    for (int j = 18; j <= 64; j++) begin
      wait_until(12 + 6 * (j - 1) + 50);
      cap = {cap[62:0], DOUT};
      if (j == 18) begin
        n_cmp++; if (DOUT !== 1'b0) begin n_bad++; $display("FAIL resume_bit14: got %b want 0", DOUT); end
      end
      if (j == 32) begin
        n_cmp++; if (WS !== 1'b1) begin n_bad++; $display("FAIL resume_ws_rise: got %b want 1", WS); end
      end
    end
    n_cmp++; if (cap !== 64'hCAFE_B00D_1357_9BDF) begin n_bad++; $display("FAIL pause_frame: got %h want cafeb00d13579bdf", cap); end
    wait_until(445);
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL pause_fs_early: got %b want 0", frame_start); end
    wait_until(446);
    n_cmp++; if ({frame_start, underrun} !== 2'b10) begin n_bad++; $display("FAIL pause_next_latch: got %b want 10", {frame_start, underrun}); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    valid = 1'b1; l_data = 32'h0000_0000; r_data = 32'hFFFF_FFFF;
    wait_until(2);
    valid = 1'b0;
    wait_until(12);
    valid = 1'b1; l_data = 32'h5555_5555; r_data = 32'hAAAA_AAAA;
    wait_until(13);
    valid = 1'b0;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL mid_buffer_full: got %b want 0", ready); end
    wait_until(246);
    n_cmp++; if ({WS, DOUT} !== 2'b11) begin n_bad++; $display("FAIL mid_k40_state: got %b want 11", {WS, DOUT}); end
    rst = 1'b1;
    step();
    n_cmp++; if ({BCLK, WS, DOUT, ready, frame_start, underrun} !== 6'b0) begin n_bad++; $display("FAIL mid_reset_outputs: got %b want 000000", {BCLK, WS, DOUT, ready, frame_start, underrun}); end
    rst = 1'b0; cyc = 0;
    wait_until(1);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_rise: got %b want 1", ready); end
    wait_until(12);
    n_cmp++; if ({frame_start, underrun} !== 2'b01) begin n_bad++; $display("FAIL mid_first_latch: got %b want 01", {frame_start, underrun}); end
    wait_until(18);
    n_cmp++; if (DOUT !== 1'b0) begin n_bad++; $display("FAIL mid_dout_zero: got %b want 0", DOUT); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_underrun();
    test_back_to_back();
    test_enable_pause();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
